// File: rtl/reg_status_cdb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_cdb_if
// Description : Bus bundle for the register status table. It groups the read
//               ports, the issue (rename) port, the CDB snoop port, the flush
//               strobe and the busy counter.
//               master : issue/decode side (drives reads, issue, CDB, flush)
//               slave  : reg_status_cdb (drives rd_val, rd_q, busy_count)
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_status_cdb_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_RD    = 3
);
    // Read ports, packed: port k occupies [k*WIDTH +: WIDTH]
    logic [NUM_RD*REG_INDEX-1:0] rd_num;
    logic [NUM_RD*WORD_SIZE-1:0] rd_val;
    logic [NUM_RD*FU_INDEX-1:0]  rd_q;

    // Issue / rename port
    logic                        iss_we;
    logic [REG_INDEX-1:0]        iss_num;
    logic [FU_INDEX-1:0]         iss_tag;

    // Common data bus snoop
    logic                        cdb_valid;
    logic [FU_INDEX-1:0]         cdb_tag;
    logic [WORD_SIZE-1:0]        cdb_data;

    // Mispredict recovery and occupancy
    logic                        flush;
    logic [REG_INDEX:0]          busy_count;

    modport master (
        output rd_num, iss_we, iss_num, iss_tag,
        output cdb_valid, cdb_tag, cdb_data, flush,
        input  rd_val, rd_q, busy_count
    );

    modport slave (
        input  rd_num, iss_we, iss_num, iss_tag,
        input  cdb_valid, cdb_tag, cdb_data, flush,
        output rd_val, rd_q, busy_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_status_cdb.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_cdb
// Description : Tomasulo register status table with CDB snooping.
//               Each architectural register holds a value and a producer tag
//               (Q, 0 = ready). NUM_RD combinational read ports, one issue
//               (rename) port, a CDB snoop that writes back results and clears
//               Q, a flush that clears every Q, and a registered busy counter.
//               Register 0 is hardwired to value 0 / Q 0.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high, clears all state
//               bus   - reg_status_cdb_if.slave (reads, issue, CDB, flush,
//                       busy_count)
// Options     : REG_STATUS_BYPASS_EN - when defined, read ports forward a
//               matching CDB broadcast combinationally in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_status_cdb #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_RD    = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    reg_status_cdb_if.slave    bus
);

    localparam int                 c_NUM_REGS = 2**REG_INDEX;
    localparam logic [REG_INDEX:0] c_BUSY_ONE = {{REG_INDEX{1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------------
    logic [WORD_SIZE-1:0] r_val [c_NUM_REGS];
    logic [FU_INDEX-1:0]  r_q   [c_NUM_REGS];
    logic [REG_INDEX:0]   r_busy_count;

    logic [WORD_SIZE-1:0] w_val_next [c_NUM_REGS];
    logic [FU_INDEX-1:0]  w_q_next   [c_NUM_REGS];
    logic [REG_INDEX:0]   w_busy_next;

    logic                 w_cdb_ok;
    logic                 w_iss_ok;

    // Tag 0 means "no producer", so a broadcast or rename with tag 0 is inert.
    // A flush discards any concurrent rename.
    assign w_cdb_ok = bus.cdb_valid && (bus.cdb_tag != '0);
    assign w_iss_ok = bus.iss_we && (bus.iss_num != '0) &&
                      (bus.iss_tag != '0) && !bus.flush;

    // ------------------------------------------------------------------------
    // Next-state computation
    // Order inside an entry matters: CDB first (value + clear), then the
    // rename overrides Q (issue wins on Q), then flush overrides everything
    // on Q while leaving the CDB value write intact.
    // busy_count is the exact popcount of the next Q vector, so it stays
    // consistent under simultaneous clear/set and re-issue to busy registers.
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy_next = '0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_val_next[i] = r_val[i];
            w_q_next[i]   = r_q[i];
            if (i == 0) begin
                w_val_next[i] = '0;
                w_q_next[i]   = '0;
            end else begin
                // Only an entry still owned by the broadcasting tag captures
                // the result; a re-renamed register ignores the stale tag.
                if (w_cdb_ok && (r_q[i] == bus.cdb_tag)) begin
                    w_val_next[i] = bus.cdb_data;
                    w_q_next[i]   = '0;
                end
                if (w_iss_ok && (bus.iss_num == REG_INDEX'(i))) begin
                    w_q_next[i] = bus.iss_tag;
                end
                if (bus.flush) begin
                    w_q_next[i] = '0;
                end
            end
            if (w_q_next[i] != '0) begin
                w_busy_next = w_busy_next + c_BUSY_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_val[i] <= '0;
                r_q[i]   <= '0;
            end
            r_busy_count <= '0;
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_val[i] <= w_val_next[i];
                r_q[i]   <= w_q_next[i];
            end
            r_busy_count <= w_busy_next;
        end
    end

    assign bus.busy_count = r_busy_count;

    // ------------------------------------------------------------------------
    // Read ports: combinational from the pre-edge table. A same-cycle rename
    // is never forwarded.
    // ------------------------------------------------------------------------
    for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
        logic [REG_INDEX-1:0] w_num;
        logic [WORD_SIZE-1:0] w_tbl_val;
        logic [FU_INDEX-1:0]  w_tbl_q;

        assign w_num     = bus.rd_num[gk*REG_INDEX +: REG_INDEX];
        // r0 is forced at the mux too, so it reads 0/0 even before reset.
        assign w_tbl_val = (w_num == '0) ? '0 : r_val[w_num];
        assign w_tbl_q   = (w_num == '0) ? '0 : r_q[w_num];

`ifdef REG_STATUS_BYPASS_EN
        logic w_fwd;
        // r0 never matches because its Q is 0 and w_cdb_ok excludes tag 0.
        assign w_fwd = w_cdb_ok && (w_tbl_q == bus.cdb_tag);
        assign bus.rd_val[gk*WORD_SIZE +: WORD_SIZE] = w_fwd ? bus.cdb_data : w_tbl_val;
        assign bus.rd_q[gk*FU_INDEX +: FU_INDEX]     = w_fwd ? '0 : w_tbl_q;
`else
        assign bus.rd_val[gk*WORD_SIZE +: WORD_SIZE] = w_tbl_val;
        assign bus.rd_q[gk*FU_INDEX +: FU_INDEX]     = w_tbl_q;
`endif
    end

    // ------------------------------------------------------------------------
    // Tags are unique owners: two entries with the same non-zero Q would make
    // the CDB clear two registers and break the busy accounting assumptions.
    // ------------------------------------------------------------------------
    logic w_dup_tag;

    always_comb begin
        w_dup_tag = 1'b0;
        for (int i = 1; i < c_NUM_REGS; i++) begin
            for (int j = i + 1; j < c_NUM_REGS; j++) begin
                if ((r_q[i] != '0) && (r_q[i] == r_q[j])) begin
                    w_dup_tag = 1'b1;
                end
            end
        end
    end

    a_unique_tags: assert property (@(posedge clk) disable iff (reset) !w_dup_tag);

endmodule
`default_nettype wire

// File: tb/tb_reg_status_cdb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_status_cdb
// Description : Self-checking bench for reg_status_cdb. Directed scenarios
//               plus a randomized run, all checked against a behavioural
//               table model (value/tag arrays updated once per clock edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_status_cdb;

    localparam int WS    = 32;
    localparam int RI    = 5;
    localparam int FI    = 3;
    localparam int NR    = 3;
    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_status_cdb_if #(.WORD_SIZE(WS), .REG_INDEX(RI), .FU_INDEX(FI), .NUM_RD(NR)) bus ();

    reg_status_cdb #(.WORD_SIZE(WS), .REG_INDEX(RI), .FU_INDEX(FI), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the architectural table
    logic [WS-1:0] m_val [NREGS];
    logic [FI-1:0] m_q   [NREGS];
    int            m_busy;

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [FI-1:0] old_q [NREGS];
        for (int r = 0; r < NREGS; r++) old_q[r] = m_q[r];
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_val[r] = '0;
                m_q[r]   = '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (bus.cdb_valid && bus.cdb_tag != 0 && old_q[r] == bus.cdb_tag) begin
                    m_val[r] = bus.cdb_data;
                    m_q[r]   = '0;
                end
            end
            if (!bus.flush && bus.iss_we && bus.iss_num != 0 && bus.iss_tag != 0)
                m_q[bus.iss_num] = bus.iss_tag;
            if (bus.flush)
                for (int r = 0; r < NREGS; r++) m_q[r] = '0;
        end
        m_busy = 0;
        for (int r = 0; r < NREGS; r++) if (m_q[r] != 0) m_busy++;
    endtask

    function automatic logic [WS-1:0] exp_rd_val(input logic [RI-1:0] n);
`ifdef REG_STATUS_BYPASS_EN
        if (bus.cdb_valid && bus.cdb_tag != 0 && m_q[n] == bus.cdb_tag) return bus.cdb_data;
`endif
        return m_val[n];
    endfunction

    function automatic logic [FI-1:0] exp_rd_q(input logic [RI-1:0] n);
`ifdef REG_STATUS_BYPASS_EN
        if (bus.cdb_valid && bus.cdb_tag != 0 && m_q[n] == bus.cdb_tag) return '0;
`endif
        return m_q[n];
    endfunction

    task automatic set_idle();
        bus.iss_we    = 1'b0;
        bus.iss_num   = '0;
        bus.iss_tag   = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_rd(input logic [RI-1:0] a, input logic [RI-1:0] b, input logic [RI-1:0] c);
        bus.rd_num = {c, b, a};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic issue(input logic [RI-1:0] n, input logic [FI-1:0] t);
        set_idle();
        bus.iss_we  = 1'b1;
        bus.iss_num = n;
        bus.iss_tag = t;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        issue(5'd8, 3'd7);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd1; bus.cdb_data = 32'hDEAD_BEEF;
        bus.flush = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_idle();
        set_rd(5'd0, 5'd1, 5'd2);
        #1;
        for (int k = 0; k < NR; k++) begin
            n_tests++;
            if (bus.rd_val[k*WS +: WS] !== 32'd0 || bus.rd_q[k*FI +: FI] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_read port%0d: got val=%h q=%0d, expected val=0 q=0",
                         k, bus.rd_val[k*WS +: WS], bus.rd_q[k*FI +: FI]);
            end
        end
        set_rd(5'd8, 5'd8, 5'd8);
        #1;
        n_tests++;
        if (bus.rd_q[FI-1:0] !== 3'd0 || bus.busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: got r8 q=%0d busy=%0d, expected q=0 busy=0",
                     bus.rd_q[FI-1:0], bus.busy_count);
        end
    endtask

    task automatic test_issue_cdb();
        issue(5'd5, 3'd3);
        tick();
        set_idle();
        set_rd(5'd0, 5'd5, 5'd0);
        #1;
        n_tests++;
        if (bus.rd_q[1*FI +: FI] !== 3'd3 || bus.busy_count !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_r5: got q=%0d busy=%0d, expected q=3 busy=1",
                     bus.rd_q[1*FI +: FI], bus.busy_count);
        end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd3; bus.cdb_data = 32'hAB;
        tick();
        set_idle();
        #1;
        n_tests++;
        if (bus.rd_val[1*WS +: WS] !== 32'hAB || bus.rd_q[1*FI +: FI] !== 3'd0 || bus.busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL cdb_r5: got val=%h q=%0d busy=%0d, expected val=ab q=0 busy=0",
                     bus.rd_val[1*WS +: WS], bus.rd_q[1*FI +: FI], bus.busy_count);
        end
    endtask

    task automatic test_stale_tag();
        issue(5'd7, 3'd2);
        tick();
        issue(5'd7, 3'd4);
        tick();
        set_idle();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd2; bus.cdb_data = 32'h55;
        tick();
        set_idle();
        set_rd(5'd0, 5'd0, 5'd7);
        #1;
        n_tests++;
        if (bus.rd_val[2*WS +: WS] !== 32'd0 || bus.rd_q[2*FI +: FI] !== 3'd4 || bus.busy_count !== 6'd1) begin
            n_fail++;
            $display("FAIL stale_tag_r7: got val=%h q=%0d busy=%0d, expected val=0 q=4 busy=1",
                     bus.rd_val[2*WS +: WS], bus.rd_q[2*FI +: FI], bus.busy_count);
        end
    endtask

    task automatic test_same_cycle();
        issue(5'd9, 3'd1);
        tick();
        issue(5'd9, 3'd5);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd1; bus.cdb_data = 32'h77;
        tick();
        set_idle();
        set_rd(5'd9, 5'd0, 5'd0);
        #1;
        n_tests++;
        if (bus.rd_val[WS-1:0] !== 32'h77 || bus.rd_q[FI-1:0] !== 3'd5 || bus.busy_count !== 6'd2) begin
            n_fail++;
            $display("FAIL same_cycle_r9: got val=%h q=%0d busy=%0d, expected val=77 q=5 busy=2",
                     bus.rd_val[WS-1:0], bus.rd_q[FI-1:0], bus.busy_count);
        end
    endtask

    task automatic test_flush();
        issue(5'd3, 3'd1);
        tick();
        issue(5'd4, 3'd2);
        tick();
        // Concurrent rename of r10 must be discarded by the flush.
        issue(5'd10, 3'd3);
        bus.flush = 1'b1;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd1; bus.cdb_data = 32'h10;
        tick();
        set_idle();
        set_rd(5'd3, 5'd4, 5'd10);
        #1;
        n_tests++;
        if (bus.rd_val[WS-1:0] !== 32'h10 || bus.rd_q !== 9'd0 || bus.busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL flush: got r3 val=%h q_all=%h busy=%0d, expected val=10 q_all=0 busy=0",
                     bus.rd_val[WS-1:0], bus.rd_q, bus.busy_count);
        end
        set_rd(5'd7, 5'd9, 5'd0);
        #1;
        n_tests++;
        if (bus.rd_q !== 9'd0 || bus.rd_val[1*WS +: WS] !== 32'h77) begin
            n_fail++;
            $display("FAIL flush_keep_values: got q_all=%h r9 val=%h, expected q_all=0 val=77",
                     bus.rd_q, bus.rd_val[1*WS +: WS]);
        end
        issue(5'd0, 3'd6);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd6; bus.cdb_data = 32'h1234;
        tick();
        set_idle();
        set_rd(5'd0, 5'd0, 5'd0);
        #1;
        n_tests++;
        if (bus.rd_val[WS-1:0] !== 32'd0 || bus.rd_q[FI-1:0] !== 3'd0 || bus.busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL r0_hardwired: got val=%h q=%0d busy=%0d, expected val=0 q=0 busy=0",
                     bus.rd_val[WS-1:0], bus.rd_q[FI-1:0], bus.busy_count);
        end
    endtask

    task automatic test_bypass();
        logic [WS-1:0] want_val;
        logic [FI-1:0] want_q;
        issue(5'd6, 3'd6);
        tick();
        set_idle();
        set_rd(5'd1, 5'd6, 5'd2);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd6; bus.cdb_data = 32'h99;
        #1;
`ifdef REG_STATUS_BYPASS_EN
        want_val = 32'h99; want_q = 3'd0;
`else
        want_val = 32'd0;  want_q = 3'd6;
`endif
        n_tests++;
        if (bus.rd_val[1*WS +: WS] !== want_val || bus.rd_q[1*FI +: FI] !== want_q) begin
            n_fail++;
            $display("FAIL bypass_pre_edge: got val=%h q=%0d, expected val=%h q=%0d",
                     bus.rd_val[1*WS +: WS], bus.rd_q[1*FI +: FI], want_val, want_q);
        end
        tick();
        set_idle();
        #1;
        n_tests++;
        if (bus.rd_val[1*WS +: WS] !== 32'h99 || bus.rd_q[1*FI +: FI] !== 3'd0 || bus.busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL bypass_post_edge: got val=%h q=%0d busy=%0d, expected val=99 q=0 busy=0",
                     bus.rd_val[1*WS +: WS], bus.rd_q[1*FI +: FI], bus.busy_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 1; t <= 7; t++) begin
            issue(RI'(10 + t), FI'(t));
            tick();
            n_tests++;
            if (bus.busy_count !== 6'(t)) begin
                n_fail++;
                $display("FAIL b2b_issue tag%0d: got busy=%0d expected %0d", t, bus.busy_count, t);
            end
        end
        for (int t = 1; t <= 7; t++) begin
            set_idle();
            bus.cdb_valid = 1'b1; bus.cdb_tag = FI'(t); bus.cdb_data = 32'hC0DE_0000 + 32'(t);
            tick();
            set_idle();
            set_rd(RI'(10 + t), 5'd0, 5'd0);
            #1;
            n_tests++;
            if (bus.busy_count !== 6'(7 - t) || bus.rd_val[WS-1:0] !== 32'hC0DE_0000 + 32'(t)
                || bus.rd_q[FI-1:0] !== 3'd0) begin
                n_fail++;
                $display("FAIL b2b_cdb tag%0d: got busy=%0d val=%h q=%0d expected busy=%0d val=%h q=0",
                         t, bus.busy_count, bus.rd_val[WS-1:0], bus.rd_q[FI-1:0], 7 - t,
                         32'hC0DE_0000 + 32'(t));
            end
        end
    endtask

    task automatic test_random();
        logic [FI-1:0] free_q [$];
        logic [RI-1:0] n;
        bit            used;
        for (int c = 0; c < 600; c++) begin
            set_idle();
            bus.rd_num = 15'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                free_q.delete();
                for (int t = 1; t < 8; t++) begin
                    used = 1'b0;
                    for (int r = 0; r < NREGS; r++) if (m_q[r] == FI'(t)) used = 1'b1;
                    if (!used) free_q.push_back(FI'(t));
                end
                bus.iss_we  = 1'b1;
                bus.iss_num = RI'($urandom);
                if (free_q.size() == 0 || $urandom_range(0, 15) == 0) bus.iss_tag = '0;
                else bus.iss_tag = free_q[$urandom_range(0, free_q.size() - 1)];
            end
            if ($urandom_range(0, 1) != 0) begin
                bus.cdb_valid = 1'b1;
                bus.cdb_tag   = FI'($urandom);
                bus.cdb_data  = $urandom;
            end
            if ($urandom_range(0, 40) == 0) bus.flush = 1'b1;
            #1;
            for (int k = 0; k < NR; k++) begin
                n = bus.rd_num[k*RI +: RI];
                n_tests++;
                if (bus.rd_val[k*WS +: WS] !== exp_rd_val(n) || bus.rd_q[k*FI +: FI] !== exp_rd_q(n)) begin
                    n_fail++;
                    $display("FAIL rand_read cyc%0d port%0d r%0d: got val=%h q=%0d expected val=%h q=%0d",
                             c, k, n, bus.rd_val[k*WS +: WS], bus.rd_q[k*FI +: FI],
                             exp_rd_val(n), exp_rd_q(n));
                end
            end
            tick();
            n_tests++;
            if (bus.busy_count !== 6'(m_busy)) begin
                n_fail++;
                $display("FAIL rand_busy cyc%0d: got %0d expected %0d", c, bus.busy_count, m_busy);
            end
        end
        set_idle();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        set_idle();
        bus.rd_num = '0;
        for (int r = 0; r < NREGS; r++) begin
            m_val[r] = '0;
            m_q[r]   = '0;
        end
        m_busy = 0;
        @(negedge clk);
        test_reset();
        test_issue_cdb();
        test_stale_tag();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_status_cdb.md
Name: reg_status_cdb

Overview:
- Parametrised successor to the Tomasulo register status table.
- Holds per architectural register a value and a producer tag (Q). Provides NUM_RD combinational read ports and one issue (rename) port.
- Snoops the common data bus (CDB): when a broadcast tag matches, the entry's value is written and Q is cleared.
- Sits between the decode/issue stage and the reservation stations. Also provides a busy-register counter and a flush for mispredict recovery.

Parameters:
- WORD_SIZE, 32, data width of each register value.
- REG_INDEX, 5, register number width; NUM_REGS = 2**REG_INDEX.
- FU_INDEX, 3, tag width. Tag 0 is reserved and means "ready, no producer".
- NUM_RD, 3, number of read ports.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state at the edge.
- rd_num  in  NUM_RD*REG_INDEX  read register numbers; port k occupies bits [k*REG_INDEX +: REG_INDEX].
- rd_val  out  NUM_RD*WORD_SIZE  read values, same packing.
- rd_q  out  NUM_RD*FU_INDEX  read producer tags, same packing.
- iss_we  in  1  issue enable: rename register iss_num to producer iss_tag.
- iss_num  in  REG_INDEX  destination register being renamed.
- iss_tag  in  FU_INDEX  new producer tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  FU_INDEX  broadcasting FU tag.
- cdb_data  in  WORD_SIZE  broadcast result.
- flush  in  1  clear all Q to 0; values are kept.
- busy_count  out  REG_INDEX+1  number of entries with Q != 0.

Behaviour:
- Reset: every value = 0, every Q = 0, busy_count = 0. Reset has priority over flush, issue and CDB in the same cycle.
- Reads are combinational from the table state. There is zero latency and no clock involvement. Reads in a given cycle see the state before that cycle's edge, so an issue in the same cycle is never visible to reads.
- Register 0 is hardwired: it always reads value 0 and Q 0. Issue and CDB writes to r0 are ignored.
- CDB, at the edge: for each entry with Q == cdb_tag, and only when cdb_valid=1 and cdb_tag != 0:
  - value <= cdb_data;
  - Q <= 0.
  - Entries whose Q differs are untouched; a stale tag never overwrites a re-renamed register.
- Issue, at the edge: if iss_we=1, iss_num != 0 and iss_tag != 0, then Q[iss_num] <= iss_tag. iss_tag = 0 is illegal and the write is ignored.
- Issue and CDB hit the same entry in the same cycle: the value takes cdb_data and Q takes iss_tag (issue wins on Q).
- Flush, at the edge: all Q <= 0 and busy_count <= 0. A concurrent CDB write still updates values; a concurrent issue is discarded.
- busy_count is registered and always equals the popcount of non-zero Q after the edge.
  - Tags are unique owners, so at most one clear and one set occur per cycle; an incremental ±1 update is acceptable.
  - A clear and a set on the same entry leave the count unchanged.
  - Re-issue to an already busy register does not increment the count.
- Stimulus with two table entries holding the same non-zero tag is illegal. Behaviour in that case is undefined and it is asserted in simulation.

Optional Feature:
- REG_STATUS_BYPASS_EN: when defined, each read port forwards the CDB in the same cycle. If cdb_valid=1, cdb_tag != 0 and the table Q of the read register equals cdb_tag, then rd_val = cdb_data and rd_q = 0, combinationally.
- When undefined, reads show the table only and the forwarded value appears the cycle after the edge.
- Issue forwarding is never provided.

Test Plan:
- Reset, then read r0..r2 -> all rd_val = 0, rd_q = 0, busy_count = 0.
- Issue r5 with tag 3; next cycle read r5 -> rd_q = 3, busy_count = 1. CDB tag 3 with data 0xAB -> next cycle r5 reads val 0xAB, q 0, busy_count = 0.
- Issue r7 tag 2, then re-issue r7 tag 4, then CDB tag 2 with data 0x55 -> r7 keeps its old value and q 4; busy_count stays 1.
- Same cycle: issue r9 tag 5 and CDB tag 1 (r9 holds tag 1) with data 0x77 -> r9 reads val 0x77, q 5, busy_count unchanged.
- Issue r3 tag 1 and r4 tag 2, then flush with CDB tag 1 data 0x10 in the same cycle -> all q 0, r3 val 0x10, busy_count 0. Issue to r0 -> r0 still reads 0/0.
- With REG_STATUS_BYPASS_EN: r6 holds q 6; drive CDB tag 6 with data 0x99 and read r6 in the same cycle -> rd_val = 0x99, rd_q = 0 before the edge. Without the macro -> rd_q = 6 until the edge.
